// File: rtl/flags_ctrl.sv
// flags_ctrl: NZCV register, lane-1 forwarding and in-flight setter scoreboard for the dual-issue pipe.
// Optional FLAGS_BYPASS_EN lets a reader issue in the same cycle its last producer resolves.
module flags_ctrl #(
  parameter int         CNT_W       = 3,
  parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
  input  logic       i_CLK,
  input  logic       i_RESET,
  input  logic [1:0] i_FlagIssueD,
  input  logic       i_FlagReadD,
  input  logic       i_FlushE,
  input  logic       i_FlagWriteE0,
  input  logic       i_FlagWriteE1,
  input  logic       i_CondExE0,
  input  logic       i_CondExE1,
  input  logic [3:0] i_ALUFlags0,
  input  logic [3:0] i_ALUFlags1,
  output logic [3:0] o_FlagsE0,
  output logic [3:0] o_FlagsE1,
  output logic       o_FlagStallD,
  output logic       o_FlagFullD,
  output logic       o_FlagErr
);
  localparam logic signed [CNT_W+1:0] MAXC    = (CNT_W+2)'((1 << CNT_W) - 1);
  localparam logic        [CNT_W-1:0] FULL_TH = CNT_W'((1 << CNT_W) - 2);
  logic                    we0, we1, under, over;
  logic [1:0]              ret;
  logic signed [CNT_W+1:0] rem, sum;
  logic [3:0]              flags_q, flags_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    err_q, err_d;
  always_comb begin
    we0     = i_FlagWriteE0 & i_CondExE0 & ~i_FlushE;
    we1     = i_FlagWriteE1 & i_CondExE1 & ~i_FlushE;
    ret     = {1'b0, i_FlagWriteE0} + {1'b0, i_FlagWriteE1};
    rem     = $signed({2'b00, count_q}) - $signed({{CNT_W{1'b0}}, ret});
    sum     = rem + $signed({{CNT_W{1'b0}}, i_FlagIssueD});
    under   = sum[CNT_W+1];
    over    = ~sum[CNT_W+1] & (sum > MAXC);
    flags_d = we1 ? i_ALUFlags1 : we0 ? i_ALUFlags0 : flags_q;
    count_d = i_FlushE ? '0 : under ? '0 : over ? '1 : sum[CNT_W-1:0];
    err_d   = err_q | (~i_FlushE & (under | over));
  end
  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      flags_q <= FLAGS_RESET;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end
  assign o_FlagsE0   = flags_q;
  assign o_FlagsE1   = we0 ? i_ALUFlags0 : flags_q;
  assign o_FlagFullD = count_q >= FULL_TH;
  assign o_FlagErr   = err_q;
`ifdef FLAGS_BYPASS_EN
  assign o_FlagStallD = i_FlagReadD & (rem != '0);
`else
  assign o_FlagStallD = i_FlagReadD & (count_q != '0);
`endif
endmodule
